// File: rtl/seg7_scan_display_if.sv
// Bus bundle for seg7_scan_display: value/load strobe in, busy and the
// multiplexed active-low digit/segment drive out, plus FSM state for debug.
//
// Handshake: load is a single-cycle strobe qualified by busy. A load seen
// in a cycle where busy is low is accepted and value_in is captured that
// same cycle. A load seen while busy is high is dropped. Nothing is queued
// and no error is flagged. busy acts as an inverted ready.
interface seg7_scan_display_if;
  logic [13:0] value_in;
  logic        load;
  logic        busy;
  logic [3:0]  dig;
  logic [7:0]  seg;
  logic [1:0]  dbg_state;

  modport master (
    output value_in, load,
    input  busy, dig, seg, dbg_state
  );

  modport slave (
    input  value_in, load,
    output busy, dig, seg, dbg_state
  );
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: captures a 14-bit binary value and converts it to BCD
// with a sequential double-dabble engine (IDLE -> CONVERT x14 -> COMMIT).
// It also time-multiplexes four digits onto an active-low 7-segment display.
// Values above 9999 show four dashes.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN. When it is defined,
// leading zero digits are blanked. The units digit is always shown.
module seg7_scan_display #(
  parameter int DIGIT_TICKS = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                 FPGA_CLK,
  input  logic                 RESET_BUT,
  seg7_scan_display_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SCAN_TC  = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [3:0]       LAST_IT  = 4'd13;
  localparam logic [7:0]       SEG_DASH = 8'hBF;
  localparam logic [7:0]       SEG_OFF  = 8'hFF;

  // Conversion engine state
  state_t      state_q;
  logic [13:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  iter_q;
  logic        busy_q;

  // Committed display value. Only COMMIT writes it, so a conversion that
  // reset aborts never shows up here.
  logic [15:0] disp_q;
  logic        ovf_q;

  // Scan state and registered pad drive
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [3:0]       dig_q;
  logic [7:0]       seg_q;

  // Combinational helpers
  logic [19:0] bcd_adj;
  logic [3:0]  nib;
  logic        blank;
  logic [7:0]  seg_d;
  logic [3:0]  dig_d;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Double-dabble add-3 step on all five BCD nibbles before each shift
  always_comb begin
    bcd_adj = {adj3(bcd_q[19:16]), adj3(bcd_q[15:12]), adj3(bcd_q[11:8]),
               adj3(bcd_q[7:4]),   adj3(bcd_q[3:0])};
  end

  // Conversion FSM: capture on load, 14 shift cycles, then one commit cycle
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load) begin
            bin_q   <= bus.value_in;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          bcd_q <= {bcd_adj[18:0], bin_q[13]};
          bin_q <= {bin_q[12:0], 1'b0};
          if (iter_q == LAST_IT) begin
            state_q <= ST_COMMIT;
          end else begin
            iter_q <= iter_q + 4'd1;
          end
        end
        ST_COMMIT: begin
          // A non-zero ten-thousands nibble means the value was above 9999
          disp_q  <= bcd_q[15:0];
          ovf_q   <= (bcd_q[19:16] != 4'd0);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running scan counter and digit index, independent of the FSM
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_q == SCAN_TC) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Select the nibble for the current digit and encode its segments
  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    case (idx_q)
      2'd0: nib = disp_q[3:0];
      2'd1: nib = disp_q[7:4];
      2'd2: nib = disp_q[11:8];
      default: nib = disp_q[15:12];
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are
    // zero. The units digit is never blanked.
    case (idx_q)
      2'd0: blank = 1'b0;
      2'd1: blank = (disp_q[15:4] == 12'd0);
      2'd2: blank = (disp_q[15:8] == 8'd0);
      default: blank = (disp_q[15:12] == 4'd0);
    endcase
`endif
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blank) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = seg_lut(nib);
    end
    dig_d = ~(4'b0001 << idx_q);
  end

  // Pad registers load only at the start of each digit slot. Digit select
  // and segments therefore change together, and a commit in mid-slot
  // cannot tear the digit currently lit.
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      dig_q <= 4'b1111;
      seg_q <= SEG_OFF;
    end else if (cnt_q == '0) begin
      dig_q <= dig_d;
      seg_q <= seg_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.dig       = dig_q;
  assign bus.seg       = seg_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Testbench for seg7_scan_display with DIGIT_TICKS=4. The expected display
// content comes from decimal arithmetic on the last accepted value.
module tb_seg7_scan_display;

  logic FPGA_CLK;
  logic RESET_BUT;
  int   n_checks;
  int   n_fail;
  int   exp_val;
  bit   exp_ovf;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg7_scan_display_if bus ();

  seg7_scan_display #(.DIGIT_TICKS(4), .CNT_W(3)) dut (
    .FPGA_CLK (FPGA_CLK),
    .RESET_BUT(RESET_BUT),
    .bus      (bus.slave)
  );

  // Clock and watchdog
  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: segment pattern for decimal position pos (0 = units)
  function automatic logic [7:0] exp_seg(input int pos);
    int pw;
    int d;
    pw = 1;
    for (int i = 0; i < pos; i++) pw = pw * 10;
    if (exp_ovf) return 8'hBF;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (pos > 0 && exp_val < pw) return 8'hFF;
`endif
    d = (exp_val / pw) % 10;
    return seg_tab[d];
  endfunction

  // Allow a full scan to settle, then check every lit digit for 4 slots
  task automatic check_display(input string tag);
    int pos;
    repeat (20) @(negedge FPGA_CLK);
    for (int k = 0; k < 16; k++) begin
      @(negedge FPGA_CLK);
      check({tag, "_dig_onehot"}, $countones(~bus.dig), 1);
      pos = 0;
      for (int b = 0; b < 4; b++) if (!bus.dig[b]) pos = b;
      check({tag, "_seg"}, {24'd0, bus.seg}, {24'd0, exp_seg(pos)});
    end
  endtask

  // Issue one load while idle and measure the busy pulse. With inject set,
  // a second load of 1111 is driven during the 5th busy cycle.
  task automatic do_load(input int v, input bit inject);
    int  nb;
    bit  done;
    @(negedge FPGA_CLK);
    bus.value_in = 14'(v);
    bus.load     = 1'b1;
    @(posedge FPGA_CLK);
    #1 bus.load = 1'b0;
    nb   = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge FPGA_CLK);
      if (bus.busy) begin
        nb++;
        if (inject && nb == 5) begin
          bus.value_in = 14'd1111;
          bus.load     = 1'b1;
        end else begin
          bus.load = 1'b0;
        end
      end else begin
        done = 1'b1;
      end
    end
    bus.load = 1'b0;
    check("busy_len", nb, 15);
    exp_val = v;
    exp_ovf = (v > 9999);
  endtask

  initial begin
    logic [3:0] exp_dig;
    int         nb;
    int         v;
    n_checks     = 0;
    n_fail       = 0;
    exp_val      = 0;
    exp_ovf      = 1'b0;
    RESET_BUT    = 1'b1;
    bus.load     = 1'b0;
    bus.value_in = '0;

    // Reset: dark display and idle
    repeat (3) begin
      @(negedge FPGA_CLK);
      check("rst_dig", bus.dig, 4'hF);
      check("rst_seg", bus.seg, 8'hFF);
      check("rst_busy", bus.busy, 1'b0);
    end
    RESET_BUT = 1'b0;

    // Scan order after reset: units first, 4 cycles per digit
    for (int k = 0; k < 16; k++) begin
      @(negedge FPGA_CLK);
      exp_dig = ~(4'b0001 << (k / 4));
      check("scan_dig", bus.dig, exp_dig);
      check("scan_seg", bus.seg, exp_seg(k / 4));
    end

    do_load(1234, 1'b0);
    check_display("v1234");

    do_load(7, 1'b0);
    check_display("v7");

    do_load(12000, 1'b0);
    check_display("v12000");

    do_load(9999, 1'b0);
    check_display("v9999");

    do_load(0, 1'b0);
    check_display("v0");

    // A second load during busy is dropped and busy does not stretch
    do_load(5678, 1'b1);
    check_display("v5678_drop");

    for (int r = 0; r < 6; r++) begin
      v = (r % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
      do_load(v, 1'b0);
      check_display("rand");
    end

    // Reset during the 8th CONVERT cycle aborts the conversion
    do_load(1234, 1'b0);
    @(negedge FPGA_CLK);
    bus.value_in = 14'd4321;
    bus.load     = 1'b1;
    @(posedge FPGA_CLK);
    #1 bus.load = 1'b0;
    nb = 0;
    for (int i = 0; i < 40 && nb < 8; i++) begin
      @(negedge FPGA_CLK);
      if (bus.busy) nb++;
    end
    check("abort_reached", nb, 8);
    RESET_BUT = 1'b1;
    @(posedge FPGA_CLK);
    #1 RESET_BUT = 1'b0;
    @(negedge FPGA_CLK);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_dig", bus.dig, 4'hF);
    check("abort_seg", bus.seg, 8'hFF);
    exp_val = 0;
    exp_ovf = 1'b0;
    check_display("abort_zero");

    do_load(42, 1'b0);
    check_display("v42");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream display stage for the key-driven counter value; drives the board's 4-digit multiplexed 7-segment display (DIG_1..DIG_4, SEG_0..SEG_7), which the top level currently ties off.
- Accepts a binary value on a load strobe and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes the four digits with registered, active-low digit and segment outputs.

Parameters:
- DIGIT_TICKS, 50000, FPGA_CLK cycles each digit stays lit (1 ms at 50 MHz); legal range 2 and up.
- CNT_W, 16, scan counter width; must satisfy 2^CNT_W > DIGIT_TICKS.

Ports:
- FPGA_CLK  in  1  system clock, 50 MHz.
- RESET_BUT  in  1  synchronous, active-high reset. The top level inverts the physical button.
- value_in  in  14  binary value to display, 0..16383.
- load  in  1  single-cycle strobe; captures value_in when the block is idle.
- busy  out  1  high while a conversion is in progress; load is ignored while busy is high.
- dig  out  4  digit enables, active-low. dig[3] is the leftmost digit (DIG_1) and dig[0] is the units digit (DIG_4).
- seg  out  8  segments, active-low. seg[7] is DP, seg[6:0] is g,f,e,d,c,b,a.

Behaviour:
- Reset (synchronous, takes priority over every other input in the same cycle):
  - FSM goes to IDLE; busy=0; dig=4'b1111; seg=8'hFF.
  - Displayed BCD registers are cleared to 0000; overflow flag cleared.
  - Scan counter and digit index are cleared to 0.
  - Reset asserted mid-conversion aborts it; the displayed value does not change to the partial result.
- FSM states:
  - IDLE: if load=1, capture value_in into the shift register, clear the BCD scratch, go to CONVERT. busy is 1 from the next cycle.
  - CONVERT: runs exactly 14 cycles. Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1. An iteration counter counts 0..13.
  - COMMIT: one cycle. Copy the scratch BCD into the display registers. Set the overflow flag if the captured value >9999. Go to IDLE.
- Latency and busy timing (load accepted in cycle 0):
  - busy=1 during cycles 1..15.
  - The display registers hold the new value from cycle 16.
  - busy=0 in cycle 16, so the next load can be accepted in cycle 16.
- A load while busy=1 is dropped: no queueing, no error.
- Scan:
  - The counter runs 0..DIGIT_TICKS-1 continuously, independent of the FSM.
  - On the terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - dig and seg are registered together, so the digit select and its segments change in the same cycle; there is no output glitch between digits.
  - Only one dig bit is low at any time after the first scan tick. The idle pattern is 1111 during reset only.
  - Updating the display mid-scan takes effect on the digit lit at the next segment register update; there is no tearing within one digit.
- Segment encoding (active-low, DP off):
  - Digits 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Dash: BF. Blank: FF.
- Overflow (captured value >9999): all four digits show dash (BF) until the next in-range load commits.
- The scan keeps running during CONVERT and shows the previous committed value.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits (thousands, hundreds, tens) show blank (FF), left to right, until the first non-zero digit.
  - The units digit is never blanked; value 0 shows "   0".
  - Blanking does not apply in overflow.
- Undefined: all four digits are always shown, so value 7 shows "0007".

Test Plan (DIGIT_TICKS=4):
- Reset held 3 cycles then released -> during reset dig=1111 and seg=FF; after reset the scan cycles dig 1110,1101,1011,0111 with 4 cycles per digit; seg=C0 on every digit (macro off).
- load with value_in=1234 -> busy high for exactly 15 cycles; thereafter dig=1110 pairs with seg=99, 1101 with B0, 1011 with A4, 0111 with F9.
- load 7 with SEG7_LEADING_ZERO_BLANK_EN defined -> units seg=F8, other three digits FF. Same stimulus with the macro undefined -> other three digits C0.
- load 12000 -> all digits BF. Then load 9999 -> all digits 90 and the dashes clear.
- load 5678, then load 1111 on the 5th busy cycle -> second load ignored; display shows 5678 (92,82,F8,80 from thousands down); busy does not extend.
- load 4321 after 1234 is committed, then RESET_BUT asserted during the 8th CONVERT cycle -> after reset the display shows 0000, busy=0, and a fresh load 42 completes normally in 16 cycles.
